// File: rtl/blit_mem_target_if.sv
// Blitter bus between the blitter master and the memory-side target.
// The master drives the request fields; the target returns ack and read data.
interface blit_mem_target_if;
  logic        mreq;
  logic        read;
  logic [3:0]  width;
  logic        justify;
  logic [23:0] address;
  logic [63:0] wdata;
  logic        ack;
  logic [63:0] rdata;
  logic        rdata_oe;

  modport master (
    output mreq, read, width, justify, address, wdata,
    input  ack, rdata, rdata_oe
  );

  modport slave (
    input  mreq, read, width, justify, address, wdata,
    output ack, rdata, rdata_oe
  );
endinterface

// File: rtl/blit_mem_target.sv
// Memory-side responder for blitter bus cycles: inserts wait states, drives a
// 64-bit phrase RAM port and returns address/data acks on the blitter bus.
module blit_mem_target #(
  parameter int unsigned WAIT_READ  = 2,
  parameter int unsigned WAIT_WRITE = 1
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  blit_mem_target_if.slave    bus,
  output logic [20:0]         mem_addr_o,
  output logic [7:0]          mem_be_o,
  output logic                mem_we_o,
  output logic                mem_re_o,
  output logic [63:0]         mem_wdata_o,
  input  logic [63:0]         mem_rdata_i,
  output logic                busy_o
);

  typedef enum logic [2:0] {StIdle, StWait, StAcc, StAack, StRgap, StDack} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [23:0] addr_q;
  logic        read_q, justify_q, pre_q, rd_pend_q;
  logic [3:0]  width_q;
  logic [63:0] wdata_q, rbuf_q, rdata_q;

  logic        capture;
  logic [3:0]  width_dec, wait_sel;
  logic [2:0]  lane;
  logic [5:0]  shamt;
  logic [4:0]  lane_end;
  logic [63:0] rdata_shift;
  logic        ack, oe;

  always_comb begin
    lane        = addr_q[2:0];
    shamt       = {lane, 3'b000};
    lane_end    = {2'b00, lane} + {1'b0, width_q};
    width_dec   = (bus.width == 4'd0 || bus.width > 4'd8) ? 4'd8 : bus.width;
    wait_sel    = bus.read ? 4'(WAIT_READ) : 4'(WAIT_WRITE);
    capture     = bus.mreq && (state_q == StIdle || state_q == StDack);
    rdata_shift = justify_q ? (rbuf_q >> shamt) : rbuf_q;
    mem_wdata_o = justify_q ? (wdata_q << shamt) : wdata_q;
    mem_addr_o  = addr_q[23:3];
    // Lanes past the phrase end are dropped rather than wrapped.
    for (int i = 0; i < 8; i++) begin
      mem_be_o[i] = (5'(i) >= {2'b00, lane}) && (5'(i) < lane_end);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack      = 1'b0;
    oe       = 1'b0;
    mem_we_o = 1'b0;
    mem_re_o = 1'b0;
    unique case (state_q)
      StIdle: ;
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StAcc;
      end
      StAcc: begin
        mem_re_o = read_q;
        mem_we_o = !read_q;
        if (pre_q) state_d = read_q ? StRgap : StIdle;
        else       state_d = StAack;
      end
      StAack: begin
        ack     = 1'b1;
        state_d = read_q ? StRgap : StIdle;
      end
      StRgap: state_d = StDack;
      StDack: begin
        ack     = 1'b1;
        oe      = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A request seen in DACK rides on the DACK ack as its address ack.
    if (capture) begin
      cnt_d   = wait_sel;
      state_d = (wait_sel != 4'd0) ? StWait : StAcc;
    end
  end

  assign bus.ack      = ack;
  assign bus.rdata_oe = oe;
  assign bus.rdata    = oe ? rdata_shift : rdata_q;
  assign busy_o       = (state_q != StIdle);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      read_q    <= 1'b0;
      width_q   <= '0;
      justify_q <= 1'b0;
      wdata_q   <= '0;
      pre_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      rbuf_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= mem_re_o;
      if (capture) begin
        addr_q    <= bus.address;
        read_q    <= bus.read;
        width_q   <= width_dec;
        justify_q <= bus.justify;
        wdata_q   <= bus.wdata;
        pre_q     <= (state_q == StDack);
      end
      // RAM data is valid the cycle after the read strobe (AACK or RGAP).
      if (rd_pend_q) rbuf_q <= mem_rdata_i;
      if (state_q == StDack) rdata_q <= rdata_shift;
    end
  end

endmodule
